// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants.
// Divide-by-zero and signed overflow finish in one cycle; everything else iterates W times.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request, o_ready high
// CALC  | one quotient bit per cycle, counter runs W..1
// DONE  | o_result valid and held until i_ack (or i_flush)
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_op,
    input  logic        i_is_32,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ack,
    output logic [63:0] o_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [6:0]  cnt;
    logic [63:0] rem_q, quo_q, div_q;
    logic        neg_q, neg_r, is_rem_q, is_32_q;

    logic        op_signed, op_rem, accept, special;
    logic [63:0] a_ext, b_ext, abs_a, abs_b, min_neg, special_sel, special_val;
    logic        sign_a, sign_b, div_zero, ovf;

    logic [64:0] rem_sh;
    logic        ge;
    logic [63:0] rem_nx, quo_nx, q_fix, r_fix, fix_sel, fix_val;

    // operand preparation and special-case detection at accept
    always_comb begin
        op_signed = ~i_op[0];
        op_rem    = i_op[1];
        if (i_is_32) begin
            a_ext = op_signed ? {{32{i_a[31]}}, i_a[31:0]} : {32'd0, i_a[31:0]};
            b_ext = op_signed ? {{32{i_b[31]}}, i_b[31:0]} : {32'd0, i_b[31:0]};
        end else begin
            a_ext = i_a;
            b_ext = i_b;
        end
        sign_a   = op_signed & a_ext[63];
        sign_b   = op_signed & b_ext[63];
        abs_a    = sign_a ? (~a_ext + 64'd1) : a_ext;
        abs_b    = sign_b ? (~b_ext + 64'd1) : b_ext;
        min_neg  = i_is_32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero = (b_ext == 64'd0);
        ovf      = op_signed & (a_ext == min_neg) & (b_ext == {64{1'b1}});
        special  = div_zero | ovf;
        if (div_zero)
            special_sel = op_rem ? a_ext : {64{1'b1}};
        else
            special_sel = op_rem ? 64'd0 : a_ext;
        special_val = i_is_32 ? {{32{special_sel[31]}}, special_sel[31:0]} : special_sel;
        accept      = i_valid & o_ready & ~i_flush;
    end

    // one restoring step plus the sign/width fixup of its result
    always_comb begin
        rem_sh  = {rem_q, quo_q[63]};
        ge      = (rem_sh >= {1'b0, div_q});
        rem_nx  = ge ? (rem_sh[63:0] - div_q) : rem_sh[63:0];
        quo_nx  = {quo_q[62:0], ge};
        q_fix   = neg_q ? (~quo_nx + 64'd1) : quo_nx;
        r_fix   = neg_r ? (~rem_nx + 64'd1) : rem_nx;
        fix_sel = is_rem_q ? r_fix : q_fix;
        fix_val = is_32_q ? {{32{fix_sel[31]}}, fix_sel[31:0]} : fix_sel;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nx = special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (i_flush)
                    state_nx = S_IDLE;
                else if (cnt == 7'd1)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                if (i_flush || i_ack)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == S_IDLE);
        o_valid = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 7'd0;
            rem_q    <= 64'd0;
            quo_q    <= 64'd0;
            div_q    <= 64'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_rem_q <= 1'b0;
            is_32_q  <= 1'b0;
            o_result <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_rem_q <= op_rem;
                        is_32_q  <= i_is_32;
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        rem_q    <= 64'd0;
                        div_q    <= abs_b;
                        // W-bit dividend sits at the top so W shifts consume it
                        quo_q    <= i_is_32 ? {abs_a[31:0], 32'd0} : abs_a;
                        cnt      <= i_is_32 ? 7'd32 : 7'd64;
                        if (special)
                            o_result <= special_val;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt - 7'd1;
                    if (cnt == 7'd1)
                        o_result <= fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule
